// File: rtl/video_timing_pkg.sv
// Shared phase encoding and default 7.14 MHz / 455x262 raster timing
// for the video timing controller.
package video_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_e;

  localparam int DEF_DIV    = 14;

  localparam int DEF_H_ACT  = 256;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 32;
  localparam int DEF_H_BP   = 151;

  localparam int DEF_V_ACT  = 224;
  localparam int DEF_V_FP   = 8;
  localparam int DEF_V_SYNC = 4;
  localparam int DEF_V_BP   = 26;

endpackage

// File: rtl/video_phase_fsm.sv
// One raster axis: position counter plus ACT/FP/SYNC/BP phase FSM with
// registered sync and blank outputs. Used for both horizontal and vertical.
module video_phase_fsm
  import video_timing_pkg::*;
#(
  parameter int ACT_LEN  = DEF_H_ACT,
  parameter int FP_LEN   = DEF_H_FP,
  parameter int SYNC_LEN = DEF_H_SYNC,
  parameter int BP_LEN   = DEF_H_BP
) (
  input  logic       clk100,
  input  logic       rst_b,
  input  logic       advance,
  input  logic       clear,
  output logic [8:0] count,
  output logic       wrap,
  output logic       sync_b,
  output logic       blank
);

  localparam logic [8:0] END_ACT  = 9'(ACT_LEN - 1);
  localparam logic [8:0] END_FP   = 9'(ACT_LEN + FP_LEN - 1);
  localparam logic [8:0] END_SYNC = 9'(ACT_LEN + FP_LEN + SYNC_LEN - 1);
  localparam logic [8:0] END_BP   = 9'(ACT_LEN + FP_LEN + SYNC_LEN + BP_LEN - 1);

  phase_e     phase_q, phase_d;
  logic [8:0] count_q, count_d;
  logic       sync_b_q, sync_b_d;
  logic       blank_q, blank_d;

  assign wrap = advance && (count_q == END_BP);

  // clear has priority so a restart never lets the axis step past 0
  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (clear) begin
      count_d = '0;
      phase_d = PH_ACT;
    end else if (advance) begin
      count_d = wrap ? '0 : count_q + 9'd1;
      case (phase_q)
        PH_ACT:  if (count_q == END_ACT)  phase_d = PH_FP;
        PH_FP:   if (count_q == END_FP)   phase_d = PH_SYNC;
        PH_SYNC: if (count_q == END_SYNC) phase_d = PH_BP;
        PH_BP:   if (count_q == END_BP)   phase_d = PH_ACT;
        default: phase_d = PH_ACT;
      endcase
    end
    sync_b_d = (phase_d != PH_SYNC);
    blank_d  = (phase_d != PH_ACT);
  end

  always_ff @(posedge clk100 or negedge rst_b) begin
    if (!rst_b) begin
      count_q  <= '0;
      phase_q  <= PH_ACT;
      sync_b_q <= 1'b1;
      blank_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      phase_q  <= phase_d;
      sync_b_q <= sync_b_d;
      blank_q  <= blank_d;
    end
  end

  assign count  = count_q;
  assign sync_b = sync_b_q;
  assign blank  = blank_q;

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator: clk100 pixel divider, restart handling and
// line/frame start markers around two phase FSMs.
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int DIV    = DEF_DIV,
  parameter int H_ACT  = DEF_H_ACT,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_ACT  = DEF_V_ACT,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic       clk100,
  input  logic       rst_b,
  input  logic       en,
  input  logic       restart,
  output logic       pix_ce,
  output logic [8:0] hcount,
  output logic [8:0] vcount,
  output logic       hsync_b,
  output logic       vsync_b,
  output logic       hblank,
  output logic       vblank,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

  if (DIV < 2 || DIV > 255 || H_TOTAL > 512 || V_TOTAL > 512 ||
      H_ACT < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACT < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $error("video_timing_ctrl: illegal DIV or segment lengths");
  end

  logic [7:0] div_q, div_d;
  logic       pix_ce_q, pix_ce_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic       advance;
  logic       h_wrap;
  logic       v_wrap;

  // pix_ce_q always mirrors div_q == DIV_LAST, so it doubles as the step qualifier
  assign advance = en && pix_ce_q && !restart;

  always_comb begin
    div_d = div_q;
    if (restart || !en) begin
      div_d = '0;
    end else if (div_q == DIV_LAST) begin
      div_d = '0;
    end else begin
      div_d = div_q + 8'd1;
    end
    pix_ce_d      = (div_d == DIV_LAST);
    line_start_d  = restart || h_wrap;
    frame_start_d = restart || v_wrap;
  end

  always_ff @(posedge clk100 or negedge rst_b) begin
    if (!rst_b) begin
      div_q         <= '0;
      pix_ce_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_ce_q      <= pix_ce_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  video_phase_fsm #(
    .ACT_LEN (H_ACT),
    .FP_LEN  (H_FP),
    .SYNC_LEN(H_SYNC),
    .BP_LEN  (H_BP)
  ) u_hfsm (
    .clk100 (clk100),
    .rst_b  (rst_b),
    .advance(advance),
    .clear  (restart),
    .count  (hcount),
    .wrap   (h_wrap),
    .sync_b (hsync_b),
    .blank  (hblank)
  );

  video_phase_fsm #(
    .ACT_LEN (V_ACT),
    .FP_LEN  (V_FP),
    .SYNC_LEN(V_SYNC),
    .BP_LEN  (V_BP)
  ) u_vfsm (
    .clk100 (clk100),
    .rst_b  (rst_b),
    .advance(h_wrap),
    .clear  (restart),
    .count  (vcount),
    .wrap   (v_wrap),
    .sync_b (vsync_b),
    .blank  (vblank)
  );

  assign pix_ce      = pix_ce_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Two instances (default timing and a shrunken raster for frame-level
// behaviour) checked every cycle against an arithmetic raster model.
module tb_video_timing_ctrl;
  import video_timing_pkg::*;

  localparam int S_DIV = 3;
  localparam int S_HA = 12, S_HF = 2, S_HS = 3, S_HB = 4;
  localparam int S_VA = 8,  S_VF = 2, S_VS = 2, S_VB = 3;

  logic clk100 = 1'b0;
  logic rst_b, en, restart;

  logic       pix_ce [2];
  logic [8:0] hcount [2];
  logic [8:0] vcount [2];
  logic       hsync_b [2];
  logic       vsync_b [2];
  logic       hblank [2];
  logic       vblank [2];
  logic       line_start [2];
  logic       frame_start [2];

  int t_div [2], t_ha [2], t_hf [2], t_hs [2], t_hb [2];
  int t_va [2], t_vf [2], t_vs [2], t_vb [2];
  int m_div [2], m_h [2], m_v [2];
  logic m_ls [2], m_fs [2];

  int check_count = 0;
  int error_count = 0;

  always #5 clk100 = ~clk100;

  video_timing_ctrl dut_std (
    .clk100(clk100), .rst_b(rst_b), .en(en), .restart(restart),
    .pix_ce(pix_ce[0]), .hcount(hcount[0]), .vcount(vcount[0]),
    .hsync_b(hsync_b[0]), .vsync_b(vsync_b[0]),
    .hblank(hblank[0]), .vblank(vblank[0]),
    .line_start(line_start[0]), .frame_start(frame_start[0])
  );

  video_timing_ctrl #(
    .DIV(S_DIV), .H_ACT(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_ACT(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) dut_small (
    .clk100(clk100), .rst_b(rst_b), .en(en), .restart(restart),
    .pix_ce(pix_ce[1]), .hcount(hcount[1]), .vcount(vcount[1]),
    .hsync_b(hsync_b[1]), .vsync_b(vsync_b[1]),
    .hblank(hblank[1]), .vblank(vblank[1]),
    .line_start(line_start[1]), .frame_start(frame_start[1])
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [24:0] actualVec(input int i);
    return {pix_ce[i], hcount[i], vcount[i], hsync_b[i], vsync_b[i],
            hblank[i], vblank[i], line_start[i], frame_start[i]};
  endfunction

  // Expected outputs follow directly from the pixel position and the segment table
  function automatic logic [24:0] expectedVec(input int i);
    int   hs0, vs0;
    logic ce, hs_b, vs_b, hb, vb;
    hs0  = t_ha[i] + t_hf[i];
    vs0  = t_va[i] + t_vf[i];
    ce   = (m_div[i] == t_div[i] - 1);
    hs_b = !(m_h[i] >= hs0 && m_h[i] < hs0 + t_hs[i]);
    vs_b = !(m_v[i] >= vs0 && m_v[i] < vs0 + t_vs[i]);
    hb   = (m_h[i] >= t_ha[i]);
    vb   = (m_v[i] >= t_va[i]);
    return {ce, 9'(m_h[i]), 9'(m_v[i]), hs_b, vs_b, hb, vb, m_ls[i], m_fs[i]};
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 2; i++) begin
      m_div[i] = 0; m_h[i] = 0; m_v[i] = 0; m_ls[i] = 1'b0; m_fs[i] = 1'b0;
    end
  endtask

  task automatic stepModel(input int i, input logic en_v, input logic rs_v);
    logic adv;
    int   htot, vtot;
    htot = t_ha[i] + t_hf[i] + t_hs[i] + t_hb[i];
    vtot = t_va[i] + t_vf[i] + t_vs[i] + t_vb[i];
    adv  = en_v && (m_div[i] == t_div[i] - 1) && !rs_v;
    m_ls[i] = 1'b0;
    m_fs[i] = 1'b0;
    if (rs_v) begin
      m_div[i] = 0; m_h[i] = 0; m_v[i] = 0; m_ls[i] = 1'b1; m_fs[i] = 1'b1;
    end else begin
      m_div[i] = en_v ? (m_div[i] + 1) % t_div[i] : 0;
      if (adv) begin
        m_h[i] = (m_h[i] + 1) % htot;
        if (m_h[i] == 0) begin
          m_ls[i] = 1'b1;
          m_v[i]  = (m_v[i] + 1) % vtot;
          if (m_v[i] == 0) m_fs[i] = 1'b1;
        end
      end
    end
  endtask

  // Called at a falling edge: drive, take one rising edge, then compare both instances
  task automatic applyStimulus(input logic en_v, input logic rs_v);
    en      = en_v;
    restart = rs_v;
    @(posedge clk100);
    stepModel(0, en_v, rs_v);
    stepModel(1, en_v, rs_v);
    @(negedge clk100);
    checkOutput("std_outputs", 32'(actualVec(0)), 32'(expectedVec(0)));
    checkOutput("small_outputs", 32'(actualVec(1)), 32'(expectedVec(1)));
  endtask

  task automatic doReset();
    en      = 1'b0;
    restart = 1'b0;
    rst_b   = 1'b0;
    #1;
    resetModel();
    checkOutput("rst_std_outputs", 32'(actualVec(0)), 32'(expectedVec(0)));
    checkOutput("rst_small_outputs", 32'(actualVec(1)), 32'(expectedVec(1)));
    checkOutput("rst_hsync_b", 32'(hsync_b[0]), 32'd1);
    checkOutput("rst_hcount", 32'(hcount[0]), 32'd0);
    checkOutput("rst_vcount", 32'(vcount[0]), 32'd0);
    @(posedge clk100);
    @(negedge clk100);
    rst_b = 1'b1;
  endtask

  initial begin
    int first_ce, h_one_edge, ls_cnt, fs_cnt, n;
    int hb_rise, sync_min, sync_max, max_h, vb_min, vb_max, vs_min, vs_max;
    logic found;

    t_div[0] = DEF_DIV; t_ha[0] = DEF_H_ACT; t_hf[0] = DEF_H_FP; t_hs[0] = DEF_H_SYNC; t_hb[0] = DEF_H_BP;
    t_va[0] = DEF_V_ACT; t_vf[0] = DEF_V_FP; t_vs[0] = DEF_V_SYNC; t_vb[0] = DEF_V_BP;
    t_div[1] = S_DIV; t_ha[1] = S_HA; t_hf[1] = S_HF; t_hs[1] = S_HS; t_hb[1] = S_HB;
    t_va[1] = S_VA; t_vf[1] = S_VF; t_vs[1] = S_VS; t_vb[1] = S_VB;

    rst_b = 1'b1; en = 1'b0; restart = 1'b0;
    resetModel();
    @(negedge clk100);
    doReset();

    // Idle with en low after reset: nothing moves, no start pulse
    for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b0);
    checkOutput("idle_line_start", 32'(line_start[0]), 32'd0);

    // Enabled cycles counted from 1; pix_ce is high during the 14th
    first_ce = 0; h_one_edge = 0;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (pix_ce[0] && first_ce == 0) first_ce = k + 1;
      if (hcount[0] == 9'd1 && h_one_edge == 0) h_one_edge = k;
    end
    checkOutput("first_ce_cycle", 32'(first_ce), 32'd14);
    checkOutput("h_inc_edge", 32'(h_one_edge), 32'd14);

    // One full line on the default instance
    hb_rise = -1; sync_min = 999; sync_max = -1; max_h = 0; ls_cnt = 0; n = 0;
    while (vcount[0] != 9'd1 && n < 7000) begin
      applyStimulus(1'b1, 1'b0);
      n++;
      if (hblank[0] && hb_rise < 0) hb_rise = int'(hcount[0]);
      if (!hsync_b[0]) begin
        if (int'(hcount[0]) < sync_min) sync_min = int'(hcount[0]);
        if (int'(hcount[0]) > sync_max) sync_max = int'(hcount[0]);
      end
      if (int'(hcount[0]) > max_h) max_h = int'(hcount[0]);
      if (line_start[0]) ls_cnt++;
    end
    checkOutput("line_vcount", 32'(vcount[0]), 32'd1);
    checkOutput("line_hcount_wrapped", 32'(hcount[0]), 32'd0);
    checkOutput("hblank_rise_h", 32'(hb_rise), 32'd256);
    checkOutput("hsync_first_h", 32'(sync_min), 32'd272);
    checkOutput("hsync_last_h", 32'(sync_max), 32'd303);
    checkOutput("hcount_max", 32'(max_h), 32'd454);
    checkOutput("line_start_count", 32'(ls_cnt), 32'd1);

    // One full frame on the shrunken raster (21 x 15 pixels, DIV 3)
    n = 0;
    while (!frame_start[1] && n < 1200) begin
      applyStimulus(1'b1, 1'b0);
      n++;
    end
    checkOutput("frame_wait", 32'(frame_start[1]), 32'd1);
    fs_cnt = 0; vb_min = 999; vb_max = -1; vs_min = 999; vs_max = -1;
    for (int k = 0; k < 21 * 15 * S_DIV; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (frame_start[1]) fs_cnt++;
      if (vblank[1]) begin
        if (int'(vcount[1]) < vb_min) vb_min = int'(vcount[1]);
        if (int'(vcount[1]) > vb_max) vb_max = int'(vcount[1]);
      end
      if (!vsync_b[1]) begin
        if (int'(vcount[1]) < vs_min) vs_min = int'(vcount[1]);
        if (int'(vcount[1]) > vs_max) vs_max = int'(vcount[1]);
      end
    end
    checkOutput("frame_start_count", 32'(fs_cnt), 32'd1);
    checkOutput("frame_start_at_period", 32'(frame_start[1]), 32'd1);
    checkOutput("vblank_first_v", 32'(vb_min), 32'd8);
    checkOutput("vblank_last_v", 32'(vb_max), 32'd14);
    checkOutput("vsync_first_v", 32'(vs_min), 32'd10);
    checkOutput("vsync_last_v", 32'(vs_max), 32'd11);

    // en dropped for 50 cycles at hcount 100
    n = 0;
    while (hcount[0] != 9'd100 && n < 7000) begin
      applyStimulus(1'b1, 1'b0);
      n++;
    end
    checkOutput("reach_h100", 32'(hcount[0]), 32'd100);
    for (int k = 0; k < 50; k++) applyStimulus(1'b0, 1'b0);
    checkOutput("frozen_hcount", 32'(hcount[0]), 32'd100);
    checkOutput("frozen_pix_ce", 32'(pix_ce[0]), 32'd0);
    first_ce = 0;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, 1'b0);
      if (pix_ce[0] && first_ce == 0) first_ce = k + 1;
    end
    checkOutput("resume_ce_cycle", 32'(first_ce), 32'd14);

    // Restart in a pix_ce cycle while both axes are in sync (small raster)
    found = 1'b0; n = 0;
    while (!found && n < 3000) begin
      applyStimulus(1'b1, 1'b0);
      n++;
      found = pix_ce[1] && hcount[1] == 9'd15 && vcount[1] == 9'd10;
    end
    checkOutput("restart_setup", 32'(found), 32'd1);
    checkOutput("restart_setup_vsync", 32'(vsync_b[1]), 32'd0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("restart_hcount", 32'(hcount[1]), 32'd0);
    checkOutput("restart_vcount", 32'(vcount[1]), 32'd0);
    checkOutput("restart_hsync_b", 32'(hsync_b[1]), 32'd1);
    checkOutput("restart_vsync_b", 32'(vsync_b[1]), 32'd1);
    checkOutput("restart_frame_start", 32'(frame_start[1]), 32'd1);
    applyStimulus(1'b1, 1'b0);
    checkOutput("restart_pulse_width", 32'(frame_start[1]), 32'd0);

    // Restart while disabled still takes effect
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    checkOutput("restart_en0_line_start", 32'(line_start[0]), 32'd1);

    // Randomised enable/restart traffic
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(logic'($urandom_range(0, 9) != 0), logic'($urandom_range(0, 199) == 0));
    end

    // Reset pulsed while the default instance is in horizontal sync
    n = 0;
    while (hsync_b[0] && n < 7000) begin
      applyStimulus(1'b1, 1'b0);
      n++;
    end
    checkOutput("reach_hsync", 32'(hsync_b[0]), 32'd0);
    doReset();
    for (int k = 0; k < 30; k++) applyStimulus(1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/video_timing_ctrl.md
VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

Interface
REQ-001 Parameter DIV, default 14: clk100 cycles per pixel (about 7.14 MHz pixel rate); legal range 2..255.
REQ-002 Parameters H_ACT/H_FP/H_SYNC/H_BP, defaults 256/16/32/151: horizontal segment lengths in pixels (H_TOTAL = 455).
REQ-003 Parameters V_ACT/V_FP/V_SYNC/V_BP, defaults 224/8/4/26: vertical segment lengths in lines (V_TOTAL = 262).
REQ-004 clk100  in  1  system clock; the only clock; all logic on its rising edge.
REQ-005 rst_b  in  1  reset; asynchronous, active-low.
REQ-006 en  in  1  run enable; low freezes all timing.
REQ-007 restart  in  1  synchronous one-cycle request to return to pixel (0,0).
REQ-008 pix_ce  out  1  one-clk100-cycle pixel strobe.
REQ-009 hcount  out  9  horizontal pixel position, 0..H_TOTAL-1.
REQ-010 vcount  out  9  vertical line position, 0..V_TOTAL-1.
REQ-011 hsync_b, vsync_b  out  1 each  active-low sync pulses.
REQ-012 hblank, vblank  out  1 each  high outside the active region.
REQ-013 line_start, frame_start  out  1 each  one-cycle markers.

Function
REQ-014 Divider counts 0..DIV-1 while en=1; pix_ce=1 exactly in cycles where divider = DIV-1; divider then wraps to 0.
REQ-015 en=0: divider held at 0; pix_ce=0; hcount, vcount, phases and all outputs hold value; on en 0->1, first pix_ce occurs DIV cycles later.
REQ-016 On pix_ce, hcount increments; at H_TOTAL-1 it wraps to 0 and vcount increments; vcount wraps from V_TOTAL-1 to 0.
REQ-017 Horizontal FSM states ACT, FP, SYNC, BP; transitions on pix_ce at hcount = H_ACT-1, H_ACT+H_FP-1, H_ACT+H_FP+H_SYNC-1, H_TOTAL-1 (BP->ACT).
REQ-018 Vertical FSM uses the same states; it advances only on pix_ce with hcount wrap, at boundaries computed from V_* parameters.
REQ-019 hsync_b=0 only in horizontal SYNC; vsync_b=0 only in vertical SYNC; hblank=1 unless horizontal ACT; vblank=1 unless vertical ACT.
REQ-020 All outputs are registered and change on the same clk100 edge as the counters they describe; no combinational path from en/restart to outputs.
REQ-021 line_start=1 for the one cycle after the edge on which hcount becomes 0; frame_start=1 for the one cycle after the edge on which both counters become 0.
REQ-022 restart=1: on the next edge, divider, hcount and vcount go to 0, both FSMs go to ACT, and line_start=frame_start=1 for one cycle; this applies even when en=0.
REQ-023 restart coinciding with pix_ce: restart wins, and no increment occurs.
REQ-024 Elaboration fails if H_TOTAL>512, V_TOTAL>512, any segment length is 0, or DIV<2.

Reset
REQ-025 rst_b low: divider=0, hcount=0, vcount=0, both FSMs in ACT, pix_ce=0, hsync_b=1, vsync_b=1, hblank=0, vblank=0, line_start=0, frame_start=0.
REQ-026 After rst_b deasserts, the first pix_ce occurs DIV cycles after the first edge with en=1; no start pulse is generated on reset release.
REQ-027 rst_b asserted mid-line or mid-frame aborts immediately to reset values; there is no partial-line completion.

Structure
REQ-028 Package video_timing_pkg holds the phase enum typedef (ACT, FP, SYNC, BP) and the default timing constants.
REQ-029 Sub-module video_phase_fsm implements one phase FSM and its counter, parameterised by segment lengths and with an advance input; it is instantiated twice (horizontal and vertical).
REQ-030 Divider, restart handling and start-pulse logic reside in the top module.

Verification
REQ-031 Reset, then en=1 with DIV=14 -> pix_ce every 14 cycles; first pix_ce on cycle 14; hcount goes 0->1 on that edge.
REQ-032 Run one full line -> hblank rises at hcount=256; hsync_b is low for hcount 272..303; hcount wraps 454->0; vcount goes 0->1; line_start fires once.
REQ-033 Run one full frame -> vblank for vcount 224..261; vsync_b low for vcount 232..235; frame_start once per 455*262*14 cycles.
REQ-034 en dropped at hcount=100 for 50 cycles -> all outputs frozen; the next pix_ce comes 14 cycles after en returns.
REQ-035 restart asserted at hcount=300, vcount=230, in the same cycle as pix_ce -> next edge gives hcount=0, vcount=0, hsync_b=1, vsync_b=1, frame_start=1.
REQ-036 rst_b pulsed low mid-sync -> outputs immediately take reset values: hsync_b=1, counters 0.
